// File: rtl/byte_unstriping_pkg.sv
// Constants shared by the byte-striping and byte-unstriping stages.
package byte_unstriping_pkg;
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam logic        LANE0         = 1'b0;
  localparam logic        LANE1         = 1'b1;
endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Per-lane skew-absorbing FIFO; a push while full is accepted only alongside a pop.
module lane_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_do_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/byte_unstriping.sv
// Merges two lane streams back into one word stream in strict lane0/lane1 order.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             lane_sel,
  output logic             overflow
);
  logic             r_rd_lane;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_lane_sel;
  logic             r_overflow;

  logic [WIDTH-1:0] w_dout0, w_dout1;
  logic             w_empty0, w_empty1;
  logic             w_full0, w_full1;
  logic             w_pop0, w_pop1;
  logic             w_drop;

  // Pop decisions use registered occupancy only, so there is no same-cycle bypass.
  assign w_pop0 = (r_rd_lane == LANE0) && !w_empty0;
  assign w_pop1 = (r_rd_lane == LANE1) && !w_empty1;
  assign w_drop = (valid_0 && w_full0 && !w_pop0) || (valid_1 && w_full1 && !w_pop1);

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .i_clk(clk_2f), .i_rst_n(reset), .i_push(valid_0), .i_pop(w_pop0),
    .i_din(lane0), .o_dout(w_dout0), .o_empty(w_empty0), .o_full(w_full0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .i_clk(clk_2f), .i_rst_n(reset), .i_push(valid_1), .i_pop(w_pop1),
    .i_din(lane1), .o_dout(w_dout1), .o_empty(w_empty1), .o_full(w_full1)
  );

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_rd_lane  <= LANE0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_lane_sel <= LANE0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop0 || w_pop1) begin
        r_data     <= (r_rd_lane == LANE1) ? w_dout1 : w_dout0;
        r_valid    <= 1'b1;
        r_lane_sel <= r_rd_lane;
        r_rd_lane  <= ~r_rd_lane;
      end else begin
        r_valid <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_sel  = r_lane_sel;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping with a queue-based reference model.
module tb_byte_unstriping;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] lane0 = '0;
  logic         valid_0 = 1'b0;
  logic [W-1:0] lane1 = '0;
  logic         valid_1 = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         lane_sel;
  logic         overflow;

  always #5 clk = ~clk;

  byte_unstriping #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_2f(clk), .reset(reset), .lane0(lane0), .valid_0(valid_0),
    .lane1(lane1), .valid_1(valid_1), .data_out(data_out),
    .valid_out(valid_out), .lane_sel(lane_sel), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: two word queues and a turn bit, stepped once per edge.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  bit          m_rd = 0;
  logic [31:0] m_data = '0;
  bit          m_valid = 0, m_sel = 0, m_ovf = 0;
  bit          live = 0;
  logic [31:0] got[$];

  always @(posedge clk) begin
    if (!reset) begin
      mq0.delete(); mq1.delete();
      m_rd = 0; m_data = '0; m_valid = 0; m_sel = 0; m_ovf = 0;
      live = 1;
    end else if (live) begin
      m_valid = 0;
      if (!m_rd && mq0.size() > 0) begin
        m_data = mq0.pop_front(); m_valid = 1; m_sel = 0; m_rd = 1;
      end else if (m_rd && mq1.size() > 0) begin
        m_data = mq1.pop_front(); m_valid = 1; m_sel = 1; m_rd = 0;
      end
      if (valid_0) begin
        if (mq0.size() < D) mq0.push_back(lane0); else m_ovf = 1;
      end
      if (valid_1) begin
        if (mq1.size() < D) mq1.push_back(lane1); else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_valid_out", 32'(valid_out), 32'(m_valid));
      check("model_data_out", data_out, m_data);
      check("model_lane_sel", 32'(lane_sel), 32'(m_sel));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      if (valid_out === 1'b1) got.push_back(data_out);
    end
  end

  task automatic step(input bit r, input bit v0, input logic [31:0] d0,
                      input bit v1, input logic [31:0] d1);
    reset = r; valid_0 = v0; lane0 = d0; valid_1 = v1; lane1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, '0);
    got.delete();
  endtask

  task automatic expect_got(input string name, input logic [31:0] exp[$]);
    check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({name, "_word"}, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    logic [31:0] e[$];

    // Reset state
    do_reset();
    check("reset_valid_out", 32'(valid_out), 32'h0);
    check("reset_data_out", data_out, 32'h0);
    check("reset_lane_sel", 32'(lane_sel), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);

    // In-order merge
    step(1, 1, 32'hAAAA0001, 0, '0);
    check("inorder_e1_valid", 32'(valid_out), 32'h0);
    step(1, 0, '0, 1, 32'hBBBB0002);
    check("inorder_e2_valid", 32'(valid_out), 32'h1);
    check("inorder_e2_data", data_out, 32'hAAAA0001);
    check("inorder_e2_sel", 32'(lane_sel), 32'h0);
    idle(1);
    check("inorder_e3_valid", 32'(valid_out), 32'h1);
    check("inorder_e3_data", data_out, 32'hBBBB0002);
    check("inorder_e3_sel", 32'(lane_sel), 32'h1);
    idle(1);
    check("inorder_e4_valid", 32'(valid_out), 32'h0);
    check("inorder_e4_hold", data_out, 32'hBBBB0002);
    e = '{32'hAAAA0001, 32'hBBBB0002};
    expect_got("inorder", e);

    // Skew: lane1 leads lane0 by three cycles
    do_reset();
    step(1, 0, '0, 1, 32'h11);
    idle(2);
    check("skew_wait_valid", 32'(valid_out), 32'h0);
    step(1, 1, 32'h22, 0, '0);
    check("skew_no_bypass", 32'(valid_out), 32'h0);
    idle(1);
    check("skew_first", data_out, 32'h22);
    idle(1);
    check("skew_second", data_out, 32'h11);
    check("skew_second_sel", 32'(lane_sel), 32'h1);
    idle(1);
    e = '{32'h22, 32'h11};
    expect_got("skew", e);

    // Overflow on lane1
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, '0, 1, 32'(i));
    check("ovf_after4", 32'(overflow), 32'h0);
    step(1, 0, '0, 1, 32'h5);
    check("ovf_after5", 32'(overflow), 32'h1);
    step(1, 1, 32'hA, 0, '0);
    step(1, 1, 32'hB, 0, '0);
    check("ovf_first_out", data_out, 32'hA);
    idle(4);
    check("ovf_sticky", 32'(overflow), 32'h1);
    e = '{32'hA, 32'h1, 32'hB, 32'h2};
    expect_got("ovf", e);

    // Reset mid-stream with words still buffered
    step(1, 1, 32'h31, 0, '0);
    step(0, 0, '0, 0, '0);
    got.delete();
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_data", data_out, 32'h0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    check("midrst_sel", 32'(lane_sel), 32'h0);
    step(1, 1, 32'h50, 1, 32'h60);
    idle(1);
    check("midrst_first", data_out, 32'h50);
    idle(2);
    e = '{32'h50, 32'h60};
    expect_got("midrst", e);

    // Full lane1 FIFO accepting a push on its pop cycle
    do_reset();
    for (int i = 5; i <= 8; i++) step(1, 0, '0, 1, 32'(i));
    step(1, 1, 32'hC, 0, '0);
    idle(1);
    step(1, 0, '0, 1, 32'h9);
    check("fullpop_ovf", 32'(overflow), 32'h0);
    check("fullpop_out", data_out, 32'h5);
    step(1, 1, 32'hD, 0, '0);
    step(1, 1, 32'hE, 0, '0);
    step(1, 1, 32'hF, 0, '0);
    step(1, 1, 32'h10, 0, '0);
    idle(8);
    check("fullpop_ovf_end", 32'(overflow), 32'h0);
    e = '{32'hC, 32'h5, 32'hD, 32'h6, 32'hE, 32'h7, 32'hF, 32'h8, 32'h10, 32'h9};
    expect_got("fullpop", e);

    // Loopback of a striped incrementing pattern
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1, 1, 32'(i), 0, '0);
      else            step(1, 0, '0, 1, 32'(i));
    end
    idle(4);
    check("loop_ovf", 32'(overflow), 32'h0);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(32'(i));
    expect_got("loop", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Receive-side merge stage directly downstream of the byte-striping stage: accepts the two 32-bit lane streams (`lane0`/`valid_0`, `lane1`/`valid_1`) and reassembles them into a single word stream in strict lane0, lane1, lane0, … order. A small per-lane FIFO absorbs inter-lane skew, so words are realigned even when the lanes arrive offset in time. Overflow is reported as a sticky error flag.

## Interface
- `WIDTH`, 32, data word width per lane and output
- `DEPTH`, 4, entries per lane FIFO; power of two, ≥ 2
- `clk_2f`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk_2f` rising edge
- `lane0`  in  WIDTH  lane 0 data word
- `valid_0`  in  1  `lane0` carries a word this cycle
- `lane1`  in  WIDTH  lane 1 data word
- `valid_1`  in  1  `lane1` carries a word this cycle
- `data_out`  out  WIDTH  reassembled word, registered
- `valid_out`  out  1  `data_out` holds a new word this cycle
- `lane_sel`  out  1  lane the current `data_out` word came from (0/1)
- `overflow`  out  1  sticky: a word was dropped on a full lane FIFO

## Operation
- Per-lane FIFO, `DEPTH` entries, with read/write pointers and occupancy count of width log2(`DEPTH`)+1.
- Push: when `valid_x`=1, the word is written unless the FIFO is full and not popping this cycle. Push while full with a same-cycle pop is accepted; occupancy is unchanged.
- Drop: when `valid_x`=1 and the FIFO is full with no pop, the word is discarded, `overflow` goes to 1 and holds until reset.
- Read selector `rd_lane` is 1 bit, resets to 0.
  - If FIFO[`rd_lane`] is non-empty (registered state): pop, `data_out`←head, `valid_out`←1, `lane_sel`←`rd_lane`, `rd_lane` toggles.
  - Otherwise: `valid_out`←0, `data_out` and `lane_sel` hold, `rd_lane` unchanged. A waiting word on the other lane is never reordered ahead.
- Pointers wrap modulo `DEPTH`.
- No bypass: a word pushed into an empty FIFO cannot be popped in the same cycle.
- Both lanes are written in the same cycle independently.

## Timing
- Reset values (reset=0 at an edge): `data_out`=0, `valid_out`=0, `lane_sel`=0, `overflow`=0, all pointers and counts 0, `rd_lane`=0.
- Reset asserted mid-operation discards all buffered words. Inputs are ignored while reset=0.
- Latency: a word sampled at edge k, when it is the head of its FIFO and its lane's turn, appears on `data_out` with `valid_out`=1 after edge k+1.
- Throughput: one word per cycle when both lanes keep pace. Back-to-back lane0 then lane1 words give consecutive `valid_out` pulses.
- Skew tolerance: a lane may lead the other by up to `DEPTH` words without loss.

## Structure
- Shared include file (used by the striping and unstriping stages): default `WIDTH`, lane index constants `LANE0`=0 and `LANE1`=1.
- One sub-module, `lane_fifo` (parameters `WIDTH`, `DEPTH`), instantiated twice.
  - Ports: push, pop, din, dout (head), empty, full.
- Top level holds `rd_lane`, the output registers and the overflow logic.

## Test plan
- In-order merge: after reset, `lane0`=0xAAAA0001 with `valid_0` at edge 1, `lane1`=0xBBBB0002 with `valid_1` at edge 2 → `data_out`=0xAAAA0001, `lane_sel`=0 after edge 2; 0xBBBB0002, `lane_sel`=1 after edge 3; `valid_out`=0 afterwards.
- Skew: `lane1`=0x11 three cycles before `lane0`=0x22 → `valid_out` stays 0 until 0x22 emerges, then 0x11 on the next cycle.
- Overflow: five `valid_1` words 0x1–0x5, no lane0 traffic → 0x1–0x4 buffered, 0x5 dropped, `overflow`=1 after the 5th edge. Then lane0 words 0xA, 0xB → output 0xA, 0x1, 0xB, 0x2.
- Full with simultaneous pop: lane1 FIFO full, its turn, new `valid_1` word 0x9 → word accepted, `overflow` stays 0, 0x9 emerges in order.
- Reset mid-stream: two words buffered, reset=0 for one edge → `valid_out`=0, `data_out`=0, `overflow`=0. After release, the first output is the next lane0 word.
- Loopback: byte-striping stage feeding this block with a 0x00000000–0x0000000F incrementing pattern → identical sequence on `data_out`, no `overflow`.
